mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  E-stage multiply/divide unit of the 5-stage MIPS pipeline. Owns HI/LO.
//  Executes mult/multu/div/divu as multi-cycle ops and mthi/mtlo as
//  single-edge writes. Serves mfhi/mflo reads.
//  Drives busy_E and startmd_E into the hazard unit, which stalls
//  F and D, and flushes E, while an op is pending.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu
//  DIV_CYCLES   10  busy cycles for div/divu
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  mdop_E     in   4   op code (`md_none, `md_mult, `md_multu, `md_div, `md_divu, `md_mthi, `md_mtlo, `md_mfhi, `md_mflo)
//  start_E    in   1   E holds a mult/multu/div/divu (decoder-driven)
//  req        in   1   exception/interrupt taken this cycle; E op is being flushed
//  srca_E     in   32  rs operand (post-forwarding)
//  srcb_E     in   32  rt operand (post-forwarding)
//  startmd_E  out  1   = start_E & ~req & ~busy_E (combinational)
//  busy_E     out  1   multi-cycle op in flight
//  mdout_E    out  32  HI if mdop_E==`md_mfhi, LO if `md_mflo, else 0 (combinational)
// BEHAVIOUR
//  Reset (async, any time, including mid-op): hi=0, lo=0, busy_E=0, cnt=0, pending results discarded.
//  Launch: on the edge where startmd_E=1, latch the result into tmp_hi/tmp_lo.
//   - mult: signed 64-bit product; multu: unsigned product; {tmp_hi,tmp_lo}=product.
//   - div/divu: tmp_lo=quotient, tmp_hi=remainder. Signed div truncates toward
//     zero; remainder takes the sign of the dividend.
//   - Load cnt=MULT_CYCLES or DIV_CYCLES; busy_E=1 from the next cycle.
//  Countdown: while busy_E, cnt decrements each edge. On the edge where cnt==1,
//   hi<=tmp_hi, lo<=tmp_lo, and busy_E<=0.
//   - Start edge T: busy is high for cycles T+1 .. T+N; the new HI/LO is
//     visible from cycle T+N+1.
//  Divide by zero (srcb_E==0 on div/divu): the op still occupies DIV_CYCLES;
//   HI and LO are left unchanged at commit.
//  mthi/mtlo: on the edge, with ~req & ~busy_E, hi<=srca_E or lo<=srca_E; no busy.
//   These never coincide with busy, because the hazard unit stalls them.
//   If they occur with busy_E=1 anyway, they are ignored.
//  mfhi/mflo: combinational read of the architectural hi/lo. No bypass of pending tmp values.
//  req=1: suppresses start, mthi, and mtlo in that cycle. An op already in
//   flight (busy_E=1) continues and commits normally, because it belongs to an
//   older retired instruction.
//  start_E while busy_E=1: ignored (hazard unit guarantees it does not occur;
//   the bench asserts this).
//  Back-to-back: commit edge and a new launch edge are distinct; a new start is
//   accepted from the first cycle busy_E=0.
// STRUCTURE
//  The `md_* op encodings belong in the shared constant.v, next to `calmudv,
//  `readmudv and `setmudv.
//  Single flat module: cnt (4 bits is enough for the defaults; size it as
//  $clog2(max)+1), busy, hi, lo, tmp_hi, tmp_lo, and a launch decode.
//  No sub-module is natural; the arithmetic is behavioural (* / %) and the
//  latency is modelled by cnt.
// TESTING
//  1. mult a=-3, b=7 at T: busy_E high T+1..T+5; from T+6, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//  2. multu a=32'hFFFFFFFF, b=2: hi=1, lo=32'hFFFFFFFE after 5 busy cycles.
//  3. div a=-7, b=2: busy 10 cycles; then lo=-3 (FFFFFFFD), hi=-1.
//     divu a=7, b=0: after 10 cycles, hi/lo unchanged.
//  4. mthi a=32'h1234 then mfhi on the next cycle: mdout_E=32'h1234, busy_E never asserted.
//     mtlo with req=1: lo unchanged.
//  5. start_E=1 with req=1: startmd_E=0, busy_E stays 0, hi/lo unchanged.
//     req during an in-flight mult: the result still commits.
//  6. Assert reset in the 3rd busy cycle of a div: busy_E=0 immediately,
//     hi=lo=0; after release, a new mult launches and completes in 5 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared types and arithmetic for the E-stage multiply/divide unit.
// Holds the op encoding, the FSM state type and the behavioural result function.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Signed divide works on magnitudes so that MIN/-1 wraps instead of trapping.
    function automatic hilo_t md_compute(input md_op_e op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        hilo_t       res;
        logic [63:0] prod;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        res   = '0;
        prod  = '0;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        quo   = '0;
        rem   = '0;
        case (op)
            MD_MULT: begin
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res  = {prod[63:32], prod[31:0]};
            end
            MD_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = {prod[63:32], prod[31:0]};
            end
            MD_DIV: begin
                if (b != 32'd0) begin
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    res.lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                    res.hi = a[31] ? (32'd0 - rem) : rem;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage pipeline <-> multiply/divide unit bundle.
// The pipeline side is the master; the unit is the slave.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    md_op_e      mdop_E;
    logic        start_E;
    logic        req;
    logic [31:0] srca_E;
    logic [31:0] srcb_E;
    logic        startmd_E;
    logic        busy_E;
    logic [31:0] mdout_E;

    modport master (
        output mdop_E,
        output start_E,
        output req,
        output srca_E,
        output srcb_E,
        input  startmd_E,
        input  busy_E,
        input  mdout_E
    );

    modport slave (
        input  mdop_E,
        input  start_E,
        input  req,
        input  srca_E,
        input  srcb_E,
        output startmd_E,
        output busy_E,
        output mdout_E
    );

endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO: results are computed at launch, parked in
// tmp registers, and committed after a fixed countdown that models latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    md_state_e        r_state;
    md_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic             r_commit_en;

    logic             w_busy;
    logic             w_launch;
    logic             w_is_div;
    logic             w_last;
    logic             w_mt_ok;
    hilo_t            w_result;
    logic [31:0]      w_mdout;

    assign w_busy   = (r_state == S_BUSY);
    assign w_launch = md.start_E & ~md.req & ~w_busy;
    assign w_is_div = md_is_div(md.mdop_E);
    assign w_last   = w_busy && (r_cnt == CNT_W'(1));
    assign w_mt_ok  = ~md.req & ~w_busy;
    assign w_result = md_compute(md.mdop_E, md.srca_E, md.srcb_E);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_next = S_BUSY;
            S_BUSY:  if (r_cnt == CNT_W'(1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A divide by zero still runs the full countdown but never writes HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_tmp_hi    <= '0;
            r_tmp_lo    <= '0;
            r_commit_en <= 1'b0;
        end else if (w_launch) begin
            r_cnt       <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_tmp_hi    <= w_result.hi;
            r_tmp_lo    <= w_result.lo;
            r_commit_en <= ~(w_is_div && (md.srcb_E == 32'd0));
        end else if (w_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            if (r_commit_en) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
        end else if (w_mt_ok) begin
            if (md.mdop_E == MD_MTHI) r_hi <= md.srca_E;
            if (md.mdop_E == MD_MTLO) r_lo <= md.srca_E;
        end
    end

    // Reads see only architectural HI/LO, never the pending tmp values.
    always_comb begin
        w_mdout = '0;
        case (md.mdop_E)
            MD_MFHI: w_mdout = r_hi;
            MD_MFLO: w_mdout = r_lo;
            default: w_mdout = '0;
        endcase
    end

    assign md.startmd_E = w_launch;
    assign md.busy_E    = w_busy;
    assign md.mdout_E   = w_mdout;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic model
// of HI/LO built on 64-bit integer math.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if md_bus();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md_bus.mdop_E  = MD_NONE;
        md_bus.start_E = 1'b0;
        md_bus.req     = 1'b0;
        md_bus.srca_E  = 32'd0;
        md_bus.srcb_E  = 32'd0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        md_bus.mdop_E = MD_MFHI;
        #1 chk({tag, " mfhi"}, md_bus.mdout_E, exp_hi);
        md_bus.mdop_E = MD_MFLO;
        #1 chk({tag, " mflo"}, md_bus.mdout_E, exp_lo);
        md_bus.mdop_E = MD_NONE;
        #1 chk({tag, " mdout none"}, md_bus.mdout_E, 32'd0);
        $display("%s: hi=%08h lo=%08h", tag, exp_hi, exp_lo);
    endtask

    // Reference: plain integer arithmetic; signed divide truncates toward zero.
    task automatic ref_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_MULTU: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_DIV: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MD_DIVU: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic run_md(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input bit req_mid);
        int n;
        n = md_is_div(op) ? 10 : 5;
        chk({tag, " idle before start"}, 32'(md_bus.busy_E), 32'd0);
        md_bus.mdop_E  = op;
        md_bus.start_E = 1'b1;
        md_bus.req     = 1'b0;
        md_bus.srca_E  = a;
        md_bus.srcb_E  = b;
        #1 chk({tag, " startmd"}, 32'(md_bus.startmd_E), 32'd1);
        tick();
        idle_inputs();
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s busy cyc%0d", tag, i), 32'(md_bus.busy_E), 32'd1);
            if (req_mid && i == 2) md_bus.req = 1'b1;
            if (i == n) read_hilo({tag, " pre-commit"}, m_hi, m_lo);
            tick();
            md_bus.req = 1'b0;
        end
        ref_model(op, a, b);
        chk({tag, " busy after"}, 32'(md_bus.busy_E), 32'd0);
        read_hilo($sformatf("%s op=%0d a=%08h b=%08h", tag, op, a, b), m_hi, m_lo);
    endtask

    task automatic do_mt(input string tag, input md_op_e op, input logic [31:0] a, input bit rq);
        chk({tag, " idle before"}, 32'(md_bus.busy_E), 32'd0);
        md_bus.mdop_E = op;
        md_bus.srca_E = a;
        md_bus.req    = rq;
        #1 chk({tag, " no startmd"}, 32'(md_bus.startmd_E), 32'd0);
        tick();
        idle_inputs();
        chk({tag, " no busy"}, 32'(md_bus.busy_E), 32'd0);
        if (!rq) begin
            if (op == MD_MTHI) m_hi = a;
            else m_lo = a;
        end
        read_hilo($sformatf("%s op=%0d a=%08h req=%0d", tag, op, a, rq), m_hi, m_lo);
    endtask

    initial begin
        md_op_e      rand_ops [6];
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        rand_ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        chk("reset busy", 32'(md_bus.busy_E), 32'd0);
        chk("reset startmd", 32'(md_bus.startmd_E), 32'd0);
        read_hilo("reset", 32'd0, 32'd0);

        run_md("mult -3*7", MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
        read_hilo("mult -3*7 const", 32'hFFFFFFFF, 32'hFFFFFFEB);

        run_md("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        read_hilo("multu const", 32'd1, 32'hFFFFFFFE);

        run_md("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        read_hilo("div -7/2 const", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu 7/0", MD_DIVU, 32'd7, 32'd0, 1'b0);
        read_hilo("divu 7/0 const", 32'hFFFFFFFF, 32'hFFFFFFFD);

        do_mt("mthi", MD_MTHI, 32'h1234, 1'b0);
        read_hilo("mthi const", 32'h1234, 32'hFFFFFFFD);
        do_mt("mtlo req", MD_MTLO, 32'hDEADBEEF, 1'b1);
        read_hilo("mtlo req const", 32'h1234, 32'hFFFFFFFD);

        md_bus.mdop_E  = MD_MULT;
        md_bus.start_E = 1'b1;
        md_bus.req     = 1'b1;
        md_bus.srca_E  = 32'd5;
        md_bus.srcb_E  = 32'd6;
        #1 chk("start+req startmd", 32'(md_bus.startmd_E), 32'd0);
        tick();
        idle_inputs();
        chk("start+req busy1", 32'(md_bus.busy_E), 32'd0);
        tick();
        chk("start+req busy2", 32'(md_bus.busy_E), 32'd0);
        read_hilo("start+req", m_hi, m_lo);

        run_md("mult req mid", MD_MULT, 32'd1000, 32'hFFFFFF00, 1'b1);

        md_bus.mdop_E  = MD_DIV;
        md_bus.start_E = 1'b1;
        md_bus.srca_E  = 32'd100;
        md_bus.srcb_E  = 32'd3;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("rst mid div busy before", 32'(md_bus.busy_E), 32'd1);
        reset = 1'b1;
        #1 chk("rst mid div busy", 32'(md_bus.busy_E), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        read_hilo("rst mid div", m_hi, m_lo);
        tick();
        reset = 1'b0;
        tick();
        run_md("mult after rst", MD_MULT, 32'd12345, 32'hFFFFE57B, 1'b0);

        for (int k = 0; k < 24; k++) begin
            op = rand_ops[$urandom_range(0, 5)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (md_is_div(op) || op == MD_MULT || op == MD_MULTU)
                run_md($sformatf("rnd%0d", k), op, a, b, 1'($urandom_range(0, 1)));
            else
                do_mt($sformatf("rnd%0d", k), op, a, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
